// File: rtl/uart_pkg.sv
// Shared UART transmit definitions: FSM state encoding and frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;
  // wide enough to hold FRAME_BITS (counter saturates there)
  localparam int BIT_CNT_W  = 4;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last clock of each bit-time.
// pre_end flags the clock before it so registered outputs can land in the last clock.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 16   // must be >= 2
) (
  input  logic clk,
  input  logic rst,       // async, active-low
  input  logic clr,       // synchronous clear, holds count at 0
  output logic bit_end,
  output logic pre_end
);

  localparam int                CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  PRE   = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  // free-running bit-time counter, wraps at the end of each bit, parked while cleared
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    cnt <= '0;
    else if (clr || cnt == LAST) cnt <= '0;
    else                         cnt <= cnt + CNT_W'(1);
  end

  assign bit_end = !clr && (cnt == LAST);
  assign pre_end = !clr && (cnt == PRE);

endmodule

// File: rtl/uart_tx_controller.sv
// UART transmitter: one 11-bit frame (start, 8 data LSB-first, parity, stop) per accepted byte.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_controller
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 9600,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,         // async, active-low
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       tx_busy,
  output logic       frame_done
`ifdef UART_TX_BREAK_EN
  ,input  logic      break_req
`endif
);

  // integer division; the result must stay >= 2 for the pre_end look-ahead
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  localparam logic [BIT_CNT_W-1:0] CNT_DATA_LAST = BIT_CNT_W'(DATA_BITS);
  localparam logic [BIT_CNT_W-1:0] CNT_STOP      = BIT_CNT_W'(FRAME_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] CNT_FULL      = BIT_CNT_W'(FRAME_BITS);

  state_t               state;
  logic [7:0]           shreg;
  logic                 par_bit;
  logic [BIT_CNT_W-1:0] bit_cnt;   // frame bit index: 0 start, 1..8 data, 9 parity, 10 stop
  logic                 bit_end;
  logic                 pre_end;

  // divider sits at 0 in IDLE so every frame/break starts a fresh bit-time
  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == ST_IDLE),
    .bit_end (bit_end),
    .pre_end (pre_end)
  );

  assign tx_ready = rst && (state == ST_IDLE);

  // frame sequencer: state, serial shift register, parity and registered line outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (bit_end && bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + BIT_CNT_W'(1);

      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          txd     <= 1'b1;
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state   <= ST_BREAK;
            txd     <= 1'b0;
            tx_busy <= 1'b1;
          end else
`endif
          if (tx_valid) begin
            shreg   <= tx_data;
            par_bit <= (^tx_data) ^ PARITY_ODD;
            state   <= ST_START;
            txd     <= 1'b0;
            tx_busy <= 1'b1;
          end
        end

        ST_START: if (bit_end) begin
          state <= ST_DATA;
          txd   <= shreg[0];
        end

        ST_DATA: if (bit_end) begin
          shreg <= shreg >> 1;
          if (bit_cnt == CNT_DATA_LAST) begin
            state <= ST_PARITY;
            txd   <= par_bit;
          end else begin
            txd   <= shreg[1];
          end
        end

        ST_PARITY: if (bit_end) begin
          state <= ST_STOP;
          txd   <= 1'b1;
        end

        ST_STOP: begin
          // a break reaches STOP with the counter already saturated, so it never pulses
          if (pre_end && bit_cnt == CNT_STOP) frame_done <= 1'b1;
          if (bit_end) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
          end
        end

`ifdef UART_TX_BREAK_EN
        ST_BREAK: if (bit_end && bit_cnt == CNT_STOP) begin
          state <= ST_STOP;
          txd   <= 1'b1;
        end
`endif

        default: begin
          state   <= ST_IDLE;
          txd     <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller at CLKS_PER_BIT = 16 (CLK_FREQ=16, BAUD=1).
// Two instances: even parity and odd parity. Inputs driven and outputs sampled on negedge.
module tb_uart_tx_controller;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic       ready0, ready1, txd0, txd1, busy0, busy1, fd0, fd1;
`ifdef UART_TX_BREAK_EN
  logic       brk0 = 1'b0, brk1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_controller #(.CLK_FREQ(16), .BAUD(1), .PARITY_ODD(1'b0)) u_even (
    .clk(clk), .rst(rst), .tx_data(data0), .tx_valid(valid0), .tx_ready(ready0),
    .txd(txd0), .tx_busy(busy0), .frame_done(fd0)
`ifdef UART_TX_BREAK_EN
    , .break_req(brk0)
`endif
  );

  uart_tx_controller #(.CLK_FREQ(16), .BAUD(1), .PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(data1), .tx_valid(valid1), .tx_ready(ready1),
    .txd(txd1), .tx_busy(busy1), .frame_done(fd1)
`ifdef UART_TX_BREAK_EN
    , .break_req(brk1)
`endif
  );

  typedef struct {
    logic        odd;
    logic [7:0]  data;
    logic [10:0] frame;   // {stop, parity, d7..d0, start}, bit 0 sent first
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // offer one byte (bounded wait for ready); returns at the negedge of the first start-bit clock
  task automatic send(input logic odd, input logic [7:0] d);
    int n = 0;
    while (!(odd ? ready1 : ready0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
    if (odd) begin data1 = d; valid1 = 1'b1; end
    else     begin data0 = d; valid0 = 1'b1; end
    @(negedge clk);
    if (odd) valid1 = 1'b0; else valid0 = 1'b0;
  endtask

  // follow one frame clock by clock; optional ignored offer on the even unit at poke_t
  task automatic watch_frame(input string nm, input logic odd, input logic [10:0] f, input int poke_t);
    int bad_txd = 0, bad_busy = 0, fd_n = 0, fd_at = -1;
    logic tx;
    for (int t = 1; t <= 11*CPB; t++) begin
      if (poke_t != 0 && t == poke_t) begin
        chk({nm, "_ready_busy"}, {31'd0, ready0}, 32'd0);
        valid0 = 1'b1;
        data0  = 8'h3C;
      end else if (poke_t != 0 && t == poke_t + 1) begin
        valid0 = 1'b0;
      end
      tx = odd ? txd1 : txd0;
      if (tx !== f[(t-1)/CPB]) bad_txd++;
      if ((t-1) % CPB == CPB/2)
        chk($sformatf("%s_bit%0d", nm, (t-1)/CPB), {31'd0, tx}, {31'd0, f[(t-1)/CPB]});
      if (odd ? fd1 : fd0) begin fd_n++; fd_at = t; end
      if (!(odd ? busy1 : busy0)) bad_busy++;
      @(negedge clk);
    end
    chk({nm, "_txd_cycles"}, bad_txd, 0);
    chk({nm, "_fd_count"}, fd_n, 1);
    chk({nm, "_fd_clock"}, fd_at, 11*CPB);
    chk({nm, "_busy_cycles"}, bad_busy, 0);
    chk({nm, "_idle_txd"}, {31'd0, odd ? txd1 : txd0}, 32'd1);
    chk({nm, "_idle_busy"}, {31'd0, odd ? busy1 : busy0}, 32'd0);
    chk({nm, "_idle_ready"}, {31'd0, odd ? ready1 : ready0}, 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] fa, fb, exp_f;
    int bad, fdn, fdt[3], low;
    logic r177, exp_t;

    vecs[0] = '{1'b0, 8'hA5, 11'b1_0_10100101_0};
    vecs[1] = '{1'b0, 8'h01, 11'b1_1_00000001_0};
    vecs[2] = '{1'b0, 8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{1'b0, 8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{1'b0, 8'h80, 11'b1_1_10000000_0};
    vecs[5] = '{1'b0, 8'h7E, 11'b1_0_01111110_0};
    vecs[6] = '{1'b1, 8'h01, 11'b1_0_00000001_0};
    vecs[7] = '{1'b1, 8'h00, 11'b1_1_00000000_0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_fd", {31'd0, fd0}, 32'd0);
    chk("rst_txd_odd", {31'd0, txd1}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_ready_odd", {31'd0, ready1}, 32'd1);

    // table of single frames
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].odd, vecs[i].data);
      watch_frame($sformatf("vec%0d", i), vecs[i].odd, vecs[i].frame, 0);
    end

    // offer 0x3C during DATA of a 0x55 frame: must be ignored
    send(1'b0, 8'h55);
    watch_frame("ignore", 1'b0, 11'b1_0_01010101_0, 50);
    low = 0;
    for (int t = 0; t < 24; t++) begin
      if (txd0 !== 1'b1 || busy0 !== 1'b0) low++;
      @(negedge clk);
    end
    chk("ignore_no_frame", low, 0);

    // back-to-back with tx_valid held: 0x00 then 0xFF
    fa = 11'b1_0_00000000_0;
    fb = 11'b1_0_11111111_0;
    bad = 0; fdn = 0; r177 = 1'b0;
    data0 = 8'h00; valid0 = 1'b1;
    @(negedge clk);
    data0 = 8'hFF;
    for (int t = 1; t <= 360; t++) begin
      if (t == 178) valid0 = 1'b0;
      if (t <= 176)      exp_t = fa[(t-1)/CPB];
      else if (t == 177) exp_t = 1'b1;
      else if (t <= 353) exp_t = fb[(t-178)/CPB];
      else               exp_t = 1'b1;
      if (txd0 !== exp_t) bad++;
      if (t == 177) r177 = ready0;
      if (fd0) begin
        if (fdn < 3) fdt[fdn] = t;
        fdn++;
      end
      @(negedge clk);
    end
    chk("b2b_txd_cycles", bad, 0);
    chk("b2b_fd_count", fdn, 2);
    chk("b2b_fd1_clock", (fdn > 0) ? fdt[0] : -1, 176);
    chk("b2b_fd2_clock", (fdn > 1) ? fdt[1] : -1, 353);
    chk("b2b_gap_ready", {31'd0, r177}, 32'd1);

    // reset at clock 50 of a frame
    send(1'b0, 8'h5A);
    repeat (49) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_txd", {31'd0, txd0}, 32'd1);
    chk("midrst_busy", {31'd0, busy0}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    fdn = 0; low = 0;
    for (int t = 0; t < 30; t++) begin
      if (fd0) fdn++;
      if (txd0 !== 1'b1) low++;
      @(negedge clk);
    end
    chk("midrst_no_fd", fdn, 0);
    chk("midrst_line_idle", low, 0);
    send(1'b0, 8'h5A);
    watch_frame("after_rst", 1'b0, 11'b1_0_01011010_0, 0);

`ifdef UART_TX_BREAK_EN
    // break has priority over a pending byte; byte follows the break's stop bit
    exp_f = 11'b1_0_10100101_0;
    bad = 0; fdn = 0; fdt[0] = -1;
    brk0 = 1'b1; valid0 = 1'b1; data0 = 8'hA5;
    @(negedge clk);
    brk0 = 1'b0;
    for (int t = 1; t <= 370; t++) begin
      if (t == 194) valid0 = 1'b0;
      if (t <= 176)      exp_t = 1'b0;
      else if (t <= 193) exp_t = 1'b1;
      else if (t <= 369) exp_t = exp_f[(t-194)/CPB];
      else               exp_t = 1'b1;
      if (txd0 !== exp_t) bad++;
      if (t == 100) begin
        chk("brk_busy", {31'd0, busy0}, 32'd1);
        chk("brk_ready", {31'd0, ready0}, 32'd0);
      end
      if (fd0) begin fdn++; fdt[0] = t; end
      @(negedge clk);
    end
    chk("brk_txd_cycles", bad, 0);
    chk("brk_fd_count", fdn, 1);
    chk("brk_fd_clock", fdt[0], 369);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
